// File: rtl/spike_mon_pkg.sv
// Shared widths and rate-window helpers for the spike ISI / rate monitor.
package spike_mon_pkg;
  localparam int ISI_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int RATE_W_DEF     = 8;
  localparam int RATE_WIN_BASE  = 8;
  // Wide enough for the longest window (2^15) minus one.
  localparam int WIN_W          = 16;

  // Last cycle index of a rate window: 2^(RATE_WIN_BASE+sel) - 1.
  function automatic logic [WIN_W-1:0] win_last(input logic [2:0] sel);
    return (WIN_W'(1) << (RATE_WIN_BASE + int'(sel))) - WIN_W'(1);
  endfunction
endpackage

// File: rtl/spike_isi_fifo.sv
// Show-ahead FIFO for ISI values; pointers carry an extra wrap bit for full/empty.
module spike_isi_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr, r_rd_ptr;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  // Write while full is only issued together with a pop, so it reuses the head slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en)          r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/spike_isi_monitor.sv
// Spike-train statistics: inter-spike interval FIFO plus windowed spike rate.
module spike_isi_monitor
  import spike_mon_pkg::*;
#(
  parameter int ISI_W      = ISI_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int RATE_W     = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              spike_in,
  input  logic [2:0]        window_sel,
  input  logic              clr,
  output logic [ISI_W-1:0]  isi_data,
  output logic              isi_valid,
  input  logic              isi_ready,
  output logic              isi_ovf,
  output logic [RATE_W-1:0] rate_out,
  output logic              rate_stb
);
  logic              r_spike_d, r_first_seen, r_ovf, r_init, r_rate_stb;
  logic [ISI_W-1:0]  r_isi_cnt;
  logic [WIN_W-1:0]  r_win_cnt, r_win_last;
  logic [RATE_W-1:0] r_spk_cnt, r_rate_out;

  logic              w_event, w_push, w_pop, w_wr_en, w_full, w_empty, w_win_end;
  logic [RATE_W-1:0] w_spk_next;

  assign w_event    = ena & spike_in & ~r_spike_d;
  assign w_push     = w_event & r_first_seen & ~clr;
  assign w_pop      = isi_valid & isi_ready;
  assign w_wr_en    = w_push & (~w_full | w_pop);
  assign w_win_end  = ena & (r_win_cnt == r_win_last);
  assign w_spk_next = (r_spk_cnt == '1) ? r_spk_cnt : r_spk_cnt + RATE_W'(w_event);

  assign isi_valid = ~w_empty;
  assign isi_ovf   = r_ovf;
  assign rate_out  = r_rate_out;
  assign rate_stb  = r_rate_stb;

  spike_isi_fifo #(.W(ISI_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .wr_en  (w_wr_en),
    .wr_data(r_isi_cnt),
    .rd_en  (w_pop),
    .rd_data(isi_data),
    .full   (w_full),
    .empty  (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_spike_d <= 1'b0;
    else        r_spike_d <= spike_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isi_cnt    <= '0;
      r_first_seen <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (clr) begin
      r_isi_cnt    <= '0;
      r_first_seen <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_event) begin
        r_isi_cnt    <= ISI_W'(1);
        r_first_seen <= 1'b1;
      end else if (ena && r_isi_cnt != '1) begin
        r_isi_cnt <= r_isi_cnt + ISI_W'(1);
      end
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  // r_init re-latches the window length on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt  <= '0;
      r_spk_cnt  <= '0;
      r_win_last <= win_last(3'd0);
      r_init     <= 1'b1;
      r_rate_out <= '0;
      r_rate_stb <= 1'b0;
    end else begin
      r_rate_stb <= 1'b0;
      r_init     <= 1'b0;
      if (clr) begin
        r_win_cnt  <= '0;
        r_spk_cnt  <= '0;
        r_win_last <= win_last(window_sel);
      end else begin
        if (r_init) r_win_last <= win_last(window_sel);
        if (w_win_end) begin
          r_rate_out <= w_spk_next;
          r_rate_stb <= 1'b1;
          r_spk_cnt  <= '0;
          r_win_cnt  <= '0;
          r_win_last <= win_last(window_sel);
        end else if (ena) begin
          r_win_cnt <= r_win_cnt + WIN_W'(1);
          r_spk_cnt <= w_spk_next;
        end
      end
    end
  end
endmodule
